// File: rtl/serial_and_scheduler_pkg.sv
// Shared types for serial_and_scheduler: FSM state encodings,
// legal parameter ranges and the index-width helper.
package serial_and_scheduler_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_REDUCE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam int N_REQ_MIN = 2;
  localparam int N_REQ_MAX = 8;
  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 32;

  function automatic int id_bits(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/and2.sv
// Two-input AND as a user-defined primitive; the single
// shared gate through which every operand bit is reduced.
primitive and2 (y, a, b);
  output y;
  input  a, b;
  table
    0 ? : 0;
    ? 0 : 0;
    1 1 : 1;
  endtable
endprimitive

// File: rtl/serial_and_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot winner from req,
// searching upward from a registered pointer that wraps.
module rr_arbiter
  import serial_and_scheduler_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             take,
  output logic [N_REQ-1:0] win_oh,
  output logic [ID_W-1:0]  win_id
);

  logic [ID_W-1:0] ptr_q;
  logic            hit;
  int              idx;

  always_comb begin
    win_oh = '0;
    win_id = '0;
    hit    = 1'b0;
    idx    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!hit && req[idx]) begin
        hit         = 1'b1;
        win_oh[idx] = 1'b1;
        win_id      = ID_W'(idx);
      end
    end
  end

  // The winner drops to lowest priority for the next search.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (take) begin
      if (win_id == ID_W'(N_REQ - 1)) ptr_q <= '0;
      else ptr_q <= win_id + 1'b1;
    end
  end

endmodule

// File: rtl/serial_and_scheduler.sv
// Serial AND reduction shared among N_REQ requesters via one and2.
// SERIAL_AND_EARLY_EXIT_EN: finish as soon as the accumulator is 0.
module serial_and_scheduler
  import serial_and_scheduler_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int ID_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] opnd,
  output logic [N_REQ-1:0]       gnt,
  output logic                   busy,
  output logic                   done,
  output logic                   result,
  output logic [ID_W-1:0]        done_id
);

  localparam int CW = $clog2(WIDTH + 1);
`ifdef SERIAL_AND_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  if (N_REQ < N_REQ_MIN || N_REQ > N_REQ_MAX ||
      WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX ||
      ID_W != id_bits(N_REQ)) begin : g_bad_cfg
    $error("serial_and_scheduler: illegal parameters");
  end

  state_t           state_q, state_d;
  logic [N_REQ-1:0] gnt_q;
  logic [ID_W-1:0]  id_q;
  logic [WIDTH-1:0] sh_q;
  logic             acc_q;
  logic [CW-1:0]    cnt_q;
  logic [N_REQ-1:0] win_oh;
  logic [ID_W-1:0]  win_id;
  logic [WIDTH-1:0] sel_opnd;
  logic             take;
  wire              acc_and;

  assign take = (state_q == S_IDLE) && (|req);

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .take   (take),
    .win_oh (win_oh),
    .win_id (win_id)
  );

  and2 u_and (acc_and, acc_q, sh_q[0]);

  always_comb begin
    sel_opnd = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_q[i]) sel_opnd = opnd[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (|req) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (WIDTH == 1 || (EARLY && !sel_opnd[0])) state_d = S_DONE;
        else state_d = S_REDUCE;
      end
      S_REDUCE: begin
        if (cnt_q == CW'(1) || (EARLY && !acc_and)) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else state_q <= state_d;
  end

  // Bit 0 seeds acc at load, so the shifter keeps only the rest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q <= '0;
      id_q  <= '0;
      sh_q  <= '0;
      acc_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (take) begin
            gnt_q <= win_oh;
            id_q  <= win_id;
          end
        end
        S_LOAD: begin
          sh_q  <= sel_opnd >> 1;
          acc_q <= sel_opnd[0];
          cnt_q <= CW'(WIDTH - 1);
        end
        S_REDUCE: begin
          acc_q <= acc_and;
          sh_q  <= sh_q >> 1;
          cnt_q <= cnt_q - 1'b1;
        end
        S_DONE: begin
          gnt_q <= '0;
        end
        default: gnt_q <= '0;
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign result  = done ? acc_q : 1'b0;
  assign done_id = done ? id_q : '0;

endmodule
